// File: rtl/pong_physics_if.sv
// Signal bundle between the game logic and the Pong motion engine: paddle and
// game controls in, pixel coordinates and miss pulses out.
interface pong_physics_if;
  logic       stop;
  logic       serve;
  logic       speed_up;
  logic       up1;
  logic       down1;
  logic       up2;
  logic       down2;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] paddle1_y;
  logic [8:0] paddle2_y;
  logic       miss1;
  logic       miss2;

  modport master (
    output stop, serve, speed_up, up1, down1, up2, down2,
    input  ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
  );

  modport slave (
    input  stop, serve, speed_up, up1, down1, up2, down2,
    output ball_x, ball_y, paddle1_y, paddle2_y, miss1, miss2
  );
endinterface

// File: rtl/pong_physics.sv
// Pong ball/paddle motion engine: frame-tick gated paddle moves, wall and
// paddle bounces, and single-cycle miss pulses for scoring.
module pong_physics #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE1_X   = 16,
  parameter int PADDLE2_X   = 616,
  parameter int PADDLE_STEP = 4,
  parameter int MAX_SPEED   = 4,
  parameter int TICK_DIV    = 833333
) (
  input  logic          clk,
  input  logic          rst_n,
  pong_physics_if.slave bus
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [9:0]       X_CTR    = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]       Y_CTR    = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [8:0]       P_CTR    = 9'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [8:0]       P_MAX    = 9'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]       X_MAX    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]       Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]       FACE1    = 10'(PADDLE1_X + PADDLE_W);
  localparam logic [9:0]       FACE2    = 10'(PADDLE2_X - BALL_SIZE);
  localparam logic [9:0]       PSTEP    = 10'(PADDLE_STEP);
  localparam logic [2:0]       SPD_MAX  = 3'(MAX_SPEED);

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_MOVE   = 2'd1,
    ST_MISSED = 2'd2
  } state_e;

  function automatic logic [8:0] paddle_next(input logic [8:0] y, input logic up,
                                             input logic dn);
    logic [9:0] yw;
    yw = {1'b0, y};
    if (up && !dn) begin
      paddle_next = (yw < PSTEP) ? 9'd0 : 9'(yw - PSTEP);
    end else if (dn && !up) begin
      paddle_next = ((yw + PSTEP) > {1'b0, P_MAX}) ? P_MAX : 9'(yw + PSTEP);
    end else begin
      paddle_next = y;
    end
  endfunction

  function automatic logic overlaps(input logic [8:0] by, input logic [8:0] py);
    overlaps = (({1'b0, by} + 10'(BALL_SIZE)) > {1'b0, py}) &&
               ({1'b0, by} < ({1'b0, py} + 10'(PADDLE_H)));
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [8:0]       ball_y_q, ball_y_d;
  logic [8:0]       paddle1_q, paddle1_d;
  logic [8:0]       paddle2_q, paddle2_d;
  logic             dx_q, dx_d;   // 1 = moving right
  logic             dy_q, dy_d;   // 1 = moving down
  logic [2:0]       speed_q, speed_d;
  logic             miss1_q, miss1_d;
  logic             miss2_q, miss2_d;

  logic             tick_s, move_s, hit1_s, hit2_s;
  logic [9:0]       spd_s, y_sum_s, x_sum_s, x_mv_s;
  logic [8:0]       y_mv_s;
  logic             dx_mv_s, dy_mv_s, miss1_mv_s, miss2_mv_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_SERVE;
      cnt_q     <= '0;
      ball_x_q  <= X_CTR;
      ball_y_q  <= Y_CTR;
      paddle1_q <= P_CTR;
      paddle2_q <= P_CTR;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      speed_q   <= 3'd1;
      miss1_q   <= 1'b0;
      miss2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      paddle1_q <= paddle1_d;
      paddle2_q <= paddle2_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      speed_q   <= speed_d;
      miss1_q   <= miss1_d;
      miss2_q   <= miss2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    paddle1_d  = paddle1_q;
    paddle2_d  = paddle2_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    speed_d    = speed_q;
    miss1_d    = 1'b0;
    miss2_d    = 1'b0;
    x_mv_s     = ball_x_q;
    y_mv_s     = ball_y_q;
    dx_mv_s    = dx_q;
    dy_mv_s    = dy_q;
    miss1_mv_s = 1'b0;
    miss2_mv_s = 1'b0;

    tick_s  = (cnt_q == CNT_LAST);
    move_s  = tick_s && !bus.stop;
    spd_s   = {7'd0, speed_q};
    y_sum_s = {1'b0, ball_y_q} + spd_s;
    x_sum_s = ball_x_q + spd_s;
    hit1_s  = overlaps(ball_y_q, paddle1_q);
    hit2_s  = overlaps(ball_y_q, paddle2_q);

    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.speed_up && (speed_q < SPD_MAX)) begin
      speed_d = speed_q + 3'd1;
    end else begin
      speed_d = speed_q;
    end

    if (move_s) begin
      paddle1_d = paddle_next(paddle1_q, bus.up1, bus.down1);
      paddle2_d = paddle_next(paddle2_q, bus.up2, bus.down2);
    end else begin
      paddle1_d = paddle1_q;
      paddle2_d = paddle2_q;
    end

    // Candidate ball move; only committed in ST_MOVE on a live tick.
    if (dy_q) begin
      if (y_sum_s >= Y_MAX) begin
        y_mv_s  = 9'(Y_MAX);
        dy_mv_s = 1'b0;
      end else begin
        y_mv_s  = 9'(y_sum_s);
      end
    end else begin
      if ({1'b0, ball_y_q} < spd_s) begin
        y_mv_s  = 9'd0;
        dy_mv_s = 1'b1;
      end else begin
        y_mv_s  = 9'({1'b0, ball_y_q} - spd_s);
      end
    end

    if (!dx_q) begin
      if ((ball_x_q >= FACE1) && (ball_x_q <= (FACE1 + spd_s)) && hit1_s) begin
        x_mv_s  = FACE1;
        dx_mv_s = 1'b1;
      end else if (ball_x_q < spd_s) begin
        x_mv_s     = 10'd0;
        miss1_mv_s = 1'b1;
      end else begin
        x_mv_s = ball_x_q - spd_s;
      end
    end else begin
      if ((ball_x_q <= FACE2) && (x_sum_s >= FACE2) && hit2_s) begin
        x_mv_s  = FACE2;
        dx_mv_s = 1'b0;
      end else if (x_sum_s >= X_MAX) begin
        x_mv_s     = X_MAX;
        miss2_mv_s = 1'b1;
      end else begin
        x_mv_s = x_sum_s;
      end
    end

    case (state_q)
      ST_SERVE: begin
        if (!bus.stop && bus.serve) begin
          state_d = ST_MOVE;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_MOVE: begin
        if (move_s) begin
          ball_x_d = x_mv_s;
          ball_y_d = y_mv_s;
          dx_d     = dx_mv_s;
          dy_d     = dy_mv_s;
          miss1_d  = miss1_mv_s;
          miss2_d  = miss2_mv_s;
          if (miss1_mv_s || miss2_mv_s) begin
            state_d = ST_MISSED;
          end else begin
            state_d = ST_MOVE;
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MISSED: begin
        // dx still points at the player who missed, so it is left as is.
        if (!bus.stop && bus.serve) begin
          ball_x_d = X_CTR;
          ball_y_d = Y_CTR;
          state_d  = ST_MOVE;
        end else begin
          state_d = ST_MISSED;
        end
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.paddle1_y = paddle1_q;
  assign bus.paddle2_y = paddle2_q;
  assign bus.miss1     = miss1_q;
  assign bus.miss2     = miss2_q;

endmodule
